// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter: FSM state
// encoding, index-width helper and the round-robin search function.
package wb_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int MAX_MASTERS = 8;
  localparam int MAX_IDX_W   = 3;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Rotate the request vector so the master after 'last' sits at bit 0,
  // take the lowest set bit, then rotate the position back to a master index.
  function automatic logic [MAX_IDX_W-1:0] next_grant(
    input logic [MAX_MASTERS-1:0] req,
    input logic [MAX_IDX_W-1:0]   last,
    input int                     n
  );
    logic [MAX_MASTERS-1:0] rot;
    int start;
    int k;
    start = (int'(last) + 1) % n;
    rot   = '0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (i < n) rot[i] = req[(start + i) % n];
    end
    k = 0;
    for (int i = MAX_MASTERS - 1; i >= 0; i--) begin
      if (rot[i]) k = i;
    end
    return MAX_IDX_W'((start + k) % n);
  endfunction

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Combinational round-robin picker: one-hot winner and its index among the
// current requesters, searching from the master after 'last'.
import wb_arb_pkg::*;

module wb_arb_rr_pick #(
  parameter int  N  = 4,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  win_oh,
  output logic [IW-1:0] win_idx,
  output logic          any_req
);

  logic [MAX_MASTERS-1:0] req_ext;
  logic [MAX_IDX_W-1:0]   last_ext;
  logic [MAX_IDX_W-1:0]   idx_ext;

  always_comb begin
    req_ext           = '0;
    req_ext[N-1:0]    = req;
    last_ext          = '0;
    last_ext[IW-1:0]  = last;
    idx_ext           = next_grant(req_ext, last_ext, N);
    win_idx           = idx_ext[IW-1:0];
    any_req           = |req;
    win_oh            = '0;
    if (any_req) win_oh[win_idx] = 1'b1;
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave among NUM_MASTERS masters;
// grant is held for a whole master cycle. Optional stall timeout: WB_ARB_TIMEOUT_EN.
import wb_arb_pkg::*;

module wb_rr_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            HCLK,
  input  logic                            HRESETn,
  input  logic [NUM_MASTERS-1:0]          m_cyc,
  input  logic [NUM_MASTERS-1:0]          m_stb,
  input  logic [NUM_MASTERS-1:0]          m_we,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_w,
  output logic [DATA_WIDTH-1:0]           m_dat_r,
  output logic [NUM_MASTERS-1:0]          m_ack,
  output logic [NUM_MASTERS-1:0]          m_err,
  output logic                            s_cyc,
  output logic                            s_stb,
  output logic                            s_we,
  output logic [ADDR_WIDTH-1:0]           s_adr,
  output logic [DATA_WIDTH-1:0]           s_dat_w,
  input  logic [DATA_WIDTH-1:0]           s_dat_r,
  input  logic                            s_ack,
  output logic [NUM_MASTERS-1:0]          grant
);

  localparam int IW = idx_width(NUM_MASTERS);

  if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("wb_rr_arbiter: NUM_MASTERS must be 2..8 and TIMEOUT_CYCLES 1..65535");
  end

  arb_state_e             state, state_nx;
  logic [IW-1:0]          last;
  logic [NUM_MASTERS-1:0] win_oh;
  logic [IW-1:0]          win_idx;
  logic                   any_req;
  logic                   busy;
  logic                   to_hit;

  wb_arb_rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req     (m_cyc),
    .last    (last),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any_req (any_req)
  );

  // 'last' doubles as the granted index while BUSY.
  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ARB_IDLE;
      grant <= '0;
      last  <= IW'(NUM_MASTERS - 1);
    end else begin
      state <= state_nx;
      if (state == ARB_IDLE && any_req) begin
        grant <= win_oh;
        last  <= win_idx;
      end else if (state_nx == ARB_IDLE) begin
        grant <= '0;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ARB_IDLE: if (any_req) state_nx = ARB_BUSY;
      ARB_BUSY: if (!m_cyc[last] || to_hit) state_nx = ARB_IDLE;
      default:  state_nx = ARB_IDLE;
    endcase
  end

  // NOTE: every output gets a default before the conditional muxing, so no latches are inferred.
  always_comb begin
    busy    = (state == ARB_BUSY);
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_w = '0;
    m_ack   = '0;
    m_err   = '0;
    if (busy) begin
      s_cyc        = m_cyc[last] & ~to_hit;
      s_stb        = m_stb[last] & ~to_hit;
      s_we         = m_we[last];
      s_adr        = m_adr[last*ADDR_WIDTH +: ADDR_WIDTH];
      s_dat_w      = m_dat_w[last*DATA_WIDTH +: DATA_WIDTH];
      m_ack[last]  = s_ack & m_stb[last] & ~to_hit;
      m_err[last]  = to_hit;
    end
  end

  assign m_dat_r = s_dat_r;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TO_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TO_W    = (TO_BITS < 8) ? 8 : TO_BITS;

  logic [TO_W-1:0] to_cnt;
  logic            stalled;

  // Raw m_stb is used so the forced-low s_stb in the error cycle cannot feed back.
  assign stalled = (state == ARB_BUSY) & m_stb[last] & ~s_ack;
  assign to_hit  = stalled & (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      to_cnt <= '0;
    end else if (state != ARB_BUSY || state_nx != ARB_BUSY || s_ack) begin
      to_cnt <= '0;
    end else if (stalled) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end
`else
  assign to_hit = 1'b0;
`endif

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed scenarios plus randomized
// tenures scored against a round-robin reference model.
module tb_wb_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic            HCLK = 1'b0;
  logic            HRESETn;
  logic [N-1:0]    m_cyc, m_stb, m_we;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat_w;
  logic [DW-1:0]   m_dat_r;
  logic [N-1:0]    m_ack, m_err, grant;
  logic            s_cyc, s_stb, s_we;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat_w, s_dat_r;
  logic            s_ack;

  int n_checks = 0;
  int n_fail   = 0;
  int model_last;

  always #5 HCLK = ~HCLK;

  wb_rr_arbiter #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_w(m_dat_w),
    .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_w(s_dat_w),
    .s_dat_r(s_dat_r), .s_ack(s_ack), .grant(grant)
  );

  // Reference: the first requester found walking forward from the last winner.
  function automatic int rr_model(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] r;
    r = '0;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0; s_ack = 1'b0;
  endtask

  task automatic randomize_buses();
    for (int i = 0; i < N; i++) begin
      m_adr[i*AW +: AW]   = $urandom;
      m_dat_w[i*DW +: DW] = $urandom;
    end
    m_we    = N'($urandom_range(0, 15));
    s_dat_r = $urandom;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge HCLK);
    HRESETn = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    model_last = N - 1;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    idle_inputs();
    m_adr = '0; m_dat_w = '0; s_dat_r = '0;
    m_cyc = '1; m_stb = '1;
    @(posedge HCLK);
    tick();
    n_checks++;
    if (grant !== '0) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    n_checks++;
    if ({s_cyc, s_stb, s_we} !== 3'b000) begin n_fail++; $display("FAIL reset_s_ctrl: got %b expected 000", {s_cyc, s_stb, s_we}); end
    n_checks++;
    if ({m_ack, m_err} !== '0) begin n_fail++; $display("FAIL reset_ack_err: got %b expected 0", {m_ack, m_err}); end
    idle_inputs();
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  task automatic test_single_read();
    int acks;
    logic [DW-1:0] rdata;
    acks = 0;
    m_adr[0 +: AW] = 32'h100;
    m_we = '0;
    m_cyc = 4'b0001; m_stb = 4'b0001;
    settle();
    n_checks++;
    if (grant !== 4'b0000 || s_cyc !== 1'b0) begin n_fail++; $display("FAIL single_latency: grant %b s_cyc %b expected 0000/0", grant, s_cyc); end
    tick();
    n_checks++;
    if (grant !== 4'b0001 || s_cyc !== 1'b1) begin n_fail++; $display("FAIL single_grant: grant %b s_cyc %b expected 0001/1", grant, s_cyc); end
    n_checks++;
    if (s_adr !== 32'h100 || s_we !== 1'b0) begin n_fail++; $display("FAIL single_adr: adr %h we %b expected 00000100/0", s_adr, s_we); end
    acks += int'(m_ack[0]);
    tick();
    rdata = $urandom;
    s_dat_r = rdata; s_ack = 1'b1;
    settle();
    acks += int'(m_ack[0]);
    n_checks++;
    if (m_dat_r !== rdata) begin n_fail++; $display("FAIL single_rdata: got %h expected %h", m_dat_r, rdata); end
    tick();
    m_cyc = '0; m_stb = '0; s_ack = 1'b0;
    settle();
    acks += int'(m_ack[0]);
    n_checks++;
    if (acks !== 1) begin n_fail++; $display("FAIL single_ack_count: got %0d expected 1", acks); end
    n_checks++;
    if (s_cyc !== 1'b0) begin n_fail++; $display("FAIL single_release: s_cyc %b expected 0", s_cyc); end
    tick();
    n_checks++;
    if (grant !== '0) begin n_fail++; $display("FAIL single_idle: grant %b expected 0000", grant); end
  endtask

  task automatic test_round_robin();
    int exp;
    do_reset();
    randomize_buses();
    m_cyc = '1; m_stb = '1;
    tick();
    for (int t = 0; t < 5; t++) begin
      exp = rr_model(m_cyc, model_last);
      n_checks++;
      if (grant !== onehot(exp)) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", t, grant, onehot(exp)); end
      n_checks++;
      if (s_adr !== m_adr[exp*AW +: AW]) begin n_fail++; $display("FAIL rr_adr[%0d]: got %h expected %h", t, s_adr, m_adr[exp*AW +: AW]); end
      s_ack = 1'b1;
      settle();
      n_checks++;
      if (m_ack !== onehot(exp)) begin n_fail++; $display("FAIL rr_ack[%0d]: got %b expected %b", t, m_ack, onehot(exp)); end
      tick();
      m_cyc[exp] = 1'b0; m_stb[exp] = 1'b0; s_ack = 1'b0;
      tick();
      n_checks++;
      if (grant !== '0) begin n_fail++; $display("FAIL rr_idle_gap[%0d]: got %b expected 0000", t, grant); end
      model_last = exp;
      m_cyc[exp] = 1'b1; m_stb[exp] = 1'b1;
      tick();
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_burst();
    do_reset();
    randomize_buses();
    m_cyc = 4'b0010; m_stb = 4'b0010;
    tick();
    n_checks++;
    if (grant !== 4'b0010) begin n_fail++; $display("FAIL burst_grant: got %b expected 0010", grant); end
    m_cyc = 4'b0110; m_stb = 4'b0110;
    for (int b = 0; b < 4; b++) begin
      s_ack = 1'b0;
      settle();
      n_checks++;
      if (m_ack !== '0) begin n_fail++; $display("FAIL burst_wait_ack[%0d]: got %b expected 0000", b, m_ack); end
      tick();
      s_ack = 1'b1;
      settle();
      n_checks++;
      if (grant !== 4'b0010 || m_ack !== 4'b0010) begin n_fail++; $display("FAIL burst_beat[%0d]: grant %b ack %b expected 0010/0010", b, grant, m_ack); end
      tick();
    end
    s_ack = 1'b0;
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    tick();
    n_checks++;
    if (grant !== '0) begin n_fail++; $display("FAIL burst_release: got %b expected 0000", grant); end
    tick();
    n_checks++;
    if (grant !== 4'b0100) begin n_fail++; $display("FAIL burst_next: got %b expected 0100", grant); end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_skip_dropped();
    do_reset();
    m_cyc = 4'b0001; m_stb = 4'b0001;
    tick();
    m_cyc = 4'b1001;
    tick();
    n_checks++;
    if (grant !== 4'b0001) begin n_fail++; $display("FAIL skip_hold: got %b expected 0001", grant); end
    m_cyc = 4'b0001;
    tick();
    m_cyc = '0; m_stb = '0;
    tick();
    n_checks++;
    if (grant !== '0) begin n_fail++; $display("FAIL skip_release: got %b expected 0000", grant); end
    tick();
    n_checks++;
    if (grant !== '0) begin n_fail++; $display("FAIL skip_no_grant: got %b expected 0000", grant); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    m_cyc = 4'b0100; m_stb = 4'b0100;
    tick();
    n_checks++;
    if (grant !== 4'b0100) begin n_fail++; $display("FAIL rst_mid_grant: got %b expected 0100", grant); end
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    #1;
    HRESETn = 1'b0;
    #1;
    n_checks++;
    if (grant !== '0 || s_cyc !== 1'b0 || s_stb !== 1'b0) begin n_fail++; $display("FAIL rst_mid_async: grant %b s_cyc %b s_stb %b expected 0000/0/0", grant, s_cyc, s_stb); end
    m_cyc = 4'b0101; m_stb = 4'b0101;
    @(negedge HCLK);
    HRESETn = 1'b1;
    tick();
    n_checks++;
    if (grant !== 4'b0001) begin n_fail++; $display("FAIL rst_mid_first: got %b expected 0001", grant); end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] req;
    logic [DW-1:0] rdata;
    int exp;
    int beats;
    int waits;
    do_reset();
    for (int t = 0; t < 24; t++) begin
      randomize_buses();
      req = N'($urandom_range(1, 15));
      m_cyc = req; m_stb = req;
      tick();
      exp = rr_model(req, model_last);
      n_checks++;
      if (grant !== onehot(exp)) begin n_fail++; $display("FAIL rand_grant[%0d]: req %b got %b expected %b", t, req, grant, onehot(exp)); end
      beats = $urandom_range(1, 3);
      for (int b = 0; b < beats; b++) begin
        waits = $urandom_range(0, 2);
        for (int w = 0; w < waits; w++) begin
          m_cyc = (N'($urandom_range(0, 15)) & ~onehot(exp)) | onehot(exp);
          s_ack = 1'b0;
          settle();
          n_checks++;
          if (m_ack !== '0 || s_cyc !== 1'b1 || s_we !== m_we[exp] || s_dat_w !== m_dat_w[exp*DW +: DW]) begin
            n_fail++;
            $display("FAIL rand_wait[%0d]: ack %b s_cyc %b we %b dat %h expected 0000/1/%b/%h", t, m_ack, s_cyc, s_we, s_dat_w, m_we[exp], m_dat_w[exp*DW +: DW]);
          end
          tick();
        end
        rdata = $urandom;
        s_dat_r = rdata; s_ack = 1'b1;
        settle();
        n_checks++;
        if (m_ack !== onehot(exp) || m_dat_r !== rdata || s_adr !== m_adr[exp*AW +: AW]) begin
          n_fail++;
          $display("FAIL rand_beat[%0d]: ack %b rdata %h adr %h expected %b/%h/%h", t, m_ack, m_dat_r, s_adr, onehot(exp), rdata, m_adr[exp*AW +: AW]);
        end
        tick();
      end
      s_ack = 1'b0; m_cyc = '0; m_stb = '0;
      model_last = exp;
      tick();
      n_checks++;
      if (grant !== '0) begin n_fail++; $display("FAIL rand_release[%0d]: got %b expected 0000", t, grant); end
    end
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    m_cyc = 4'b0011; m_stb = 4'b0011;
    tick();
    n_checks++;
    if (grant !== 4'b0001) begin n_fail++; $display("FAIL to_grant: got %b expected 0001", grant); end
    for (int k = 1; k <= TO; k++) begin
      n_checks++;
      if (k < TO) begin
        if (m_err !== '0 || s_stb !== 1'b1) begin n_fail++; $display("FAIL to_early[%0d]: err %b s_stb %b expected 0000/1", k, m_err, s_stb); end
      end else begin
        if (m_err !== 4'b0001 || s_cyc !== 1'b0 || s_stb !== 1'b0) begin n_fail++; $display("FAIL to_err: err %b s_cyc %b s_stb %b expected 0001/0/0", m_err, s_cyc, s_stb); end
      end
      tick();
    end
    n_checks++;
    if (grant !== '0 || m_err !== '0) begin n_fail++; $display("FAIL to_clear: grant %b err %b expected 0000/0000", grant, m_err); end
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; s_ack = 1'b1;
    settle();
    n_checks++;
    if (m_ack !== '0) begin n_fail++; $display("FAIL to_late_ack: got %b expected 0000", m_ack); end
    s_ack = 1'b0;
    tick();
    n_checks++;
    if (grant !== 4'b0010) begin n_fail++; $display("FAIL to_next: got %b expected 0010", grant); end
    idle_inputs();
    tick();
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_burst();
    test_skip_dropped();
    test_reset_mid_burst();
    test_random();
`ifdef WB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
